mips_decode_stage: RTL and testbench

- Registered, parametrised MIPS instruction decode stage with a valid/ready handshake on both sides.
- Splits each accepted instruction into the standard fields, classifies it as R, I or J type, and produces a sign-, zero- or LUI-extended immediate.
- Holds decoded results in a DEPTH-entry buffer so fetch and execute can stall independently.
- Sits between instruction fetch and register read / execute in the pipelined datapath.

---
 rtl/mips_decode_stage_if.sv | 38 +++
 rtl/mips_decode_stage.sv | 98 +++++++++
 tb/tb_mips_decode_stage.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_decode_stage_if.sv
// Fetch-side handshake, execute-side handshake and decoded fields of mips_decode_stage.
// master is the producer/consumer side, slave is the decode stage itself.
interface mips_decode_stage_if #(
    parameter int unsigned EXT_WIDTH = 32,
    parameter int unsigned DEPTH     = 2
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          instruction_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [5:0]           op_out;
    logic [5:0]           func_out;
    logic [4:0]           rs_out;
    logic [4:0]           rt_out;
    logic [4:0]           rd_out;
    logic [4:0]           shft_out;
    logic [15:0]          imm16_out;
    logic [EXT_WIDTH-1:0] imm_ext_out;
    logic [25:0]          target_out;
    logic [1:0]           class_out;
    logic [CW-1:0]        count_out;

    modport master (
        output flush, in_valid, instruction_in, out_ready,
        input  in_ready, out_valid, op_out, func_out, rs_out, rt_out, rd_out, shft_out,
        input  imm16_out, imm_ext_out, target_out, class_out, count_out
    );

    modport slave (
        input  flush, in_valid, instruction_in, out_ready,
        output in_ready, out_valid, op_out, func_out, rs_out, rt_out, rd_out, shft_out,
        output imm16_out, imm_ext_out, target_out, class_out, count_out
    );
endinterface

// File: rtl/mips_decode_stage.sv
// Registered MIPS decode stage: decodes on push, buffers DEPTH decoded entries in a FIFO,
// and presents the head entry's fields (all zero while empty).
module mips_decode_stage #(
    parameter int unsigned EXT_WIDTH = 32,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned CW        = $clog2(DEPTH + 1)
) (
    input logic                clk,
    input logic                reset,
    mips_decode_stage_if.slave bus
);
    localparam int unsigned   PW   = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [31:0]          instr;
        logic [1:0]           cls;
        logic [EXT_WIDTH-1:0] imm_ext;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic [5:0]    w_op;
    logic [15:0]   w_imm16;
    entry_t        w_dec;
    entry_t        w_head;

    assign bus.in_ready  = (r_count != FULL);
    assign bus.out_valid = (r_count != '0);
    assign w_push        = bus.in_valid && bus.in_ready;
    assign w_pop         = bus.out_valid && bus.out_ready;

    always_comb begin
        w_op          = bus.instruction_in[31:26];
        w_imm16       = bus.instruction_in[15:0];
        w_dec         = '0;
        w_dec.instr   = bus.instruction_in;
        w_dec.cls     = 2'd1;
        w_dec.imm_ext = EXT_WIDTH'($signed(w_imm16));
        if (w_op == 6'd0) begin
            w_dec.cls = 2'd0;
        end else if (w_op == 6'd2 || w_op == 6'd3) begin
            w_dec.cls = 2'd2;
        end
        case (w_op)
            6'd12, 6'd13, 6'd14: w_dec.imm_ext = EXT_WIDTH'(w_imm16);
            // lui places imm16 in the upper half of a 32-bit word, then sign-extends that word
            6'd15:               w_dec.imm_ext = EXT_WIDTH'($signed({w_imm16, 16'h0000}));
            default:             ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (bus.flush) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (w_push && !bus.flush) begin
            r_mem[r_wr_ptr] <= w_dec;
        end
    end

    assign w_head = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

    assign bus.op_out      = w_head.instr[31:26];
    assign bus.rs_out      = w_head.instr[25:21];
    assign bus.rt_out      = w_head.instr[20:16];
    assign bus.rd_out      = w_head.instr[15:11];
    assign bus.shft_out    = w_head.instr[10:6];
    assign bus.func_out    = w_head.instr[5:0];
    assign bus.imm16_out   = w_head.instr[15:0];
    assign bus.target_out  = w_head.instr[25:0];
    assign bus.class_out   = w_head.cls;
    assign bus.imm_ext_out = w_head.imm_ext;
    assign bus.count_out   = r_count;
endmodule

// File: tb/tb_mips_decode_stage.sv
// Randomised and directed bench for mips_decode_stage; 32- and 64-bit immediate instances
// share one stimulus stream and one queue-based reference model.
module tb_mips_decode_stage;
    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [31:0] model_q[$];
    bit          last_push;

    mips_decode_stage_if #(.EXT_WIDTH(32), .DEPTH(DEPTH)) bus32 ();
    mips_decode_stage_if #(.EXT_WIDTH(64), .DEPTH(DEPTH)) bus64 ();

    assign bus32.flush          = flush;
    assign bus32.in_valid       = in_valid;
    assign bus32.instruction_in = instr;
    assign bus32.out_ready      = out_ready;
    assign bus64.flush          = flush;
    assign bus64.in_valid       = in_valid;
    assign bus64.instruction_in = instr;
    assign bus64.out_ready      = out_ready;

    mips_decode_stage #(.EXT_WIDTH(32), .DEPTH(DEPTH)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32)
    );

    mips_decode_stage #(.EXT_WIDTH(64), .DEPTH(DEPTH)) dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus64)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_imm(input logic [31:0] ins);
        int unsigned op;
        logic [15:0] k;
        op = int'(ins[31:26]);
        k  = ins[15:0];
        if (op >= 12 && op <= 14) return {48'h0, k};
        if (op == 15)             return {{32{k[15]}}, k, 16'h0000};
        return {{48{k[15]}}, k};
    endfunction

    function automatic logic [1:0] ref_class(input logic [31:0] ins);
        int unsigned op;
        op = int'(ins[31:26]);
        if (op == 0)            return 2'd0;
        if (op == 2 || op == 3) return 2'd2;
        return 2'd1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] h;
        logic [63:0] imm;
        logic        have;
        have = (model_q.size() != 0);
        h    = have ? model_q[0] : 32'h0;
        imm  = have ? ref_imm(h) : 64'h0;
        check("out_valid", {63'h0, bus32.out_valid}, {63'h0, have});
        check("in_ready",  {63'h0, bus32.in_ready}, (model_q.size() < DEPTH) ? 64'h1 : 64'h0);
        check("count",     64'(bus32.count_out), 64'(model_q.size()));
        check("op",        64'(bus32.op_out),     64'(h[31:26]));
        check("rs",        64'(bus32.rs_out),     64'(h[25:21]));
        check("rt",        64'(bus32.rt_out),     64'(h[20:16]));
        check("rd",        64'(bus32.rd_out),     64'(h[15:11]));
        check("shft",      64'(bus32.shft_out),   64'(h[10:6]));
        check("func",      64'(bus32.func_out),   64'(h[5:0]));
        check("imm16",     64'(bus32.imm16_out),  64'(h[15:0]));
        check("target",    64'(bus32.target_out), 64'(h[25:0]));
        check("class",     64'(bus32.class_out),  have ? 64'(ref_class(h)) : 64'h0);
        check("imm_ext32", 64'(bus32.imm_ext_out), {32'h0, imm[31:0]});
        check("imm_ext64", bus64.imm_ext_out, imm);
        check("count64",   64'(bus64.count_out), 64'(model_q.size()));
        check("class64",   64'(bus64.class_out), have ? 64'(ref_class(h)) : 64'h0);
    endtask

    // One clock: predict transfers from model occupancy, advance model, then sample outputs.
    task automatic step();
        bit push;
        bit pop;
        push = in_valid && (model_q.size() < DEPTH);
        pop  = out_ready && (model_q.size() != 0);
        @(posedge clk);
        if (flush) begin
            model_q.delete();
            last_push = 1'b0;
        end else begin
            if (pop)  void'(model_q.pop_front());
            if (push) model_q.push_back(instr);
            last_push = push;
        end
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [11];
        ops = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd8, 6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43};
        if ($urandom_range(0, 3) == 0) return $urandom;
        return {ops[$urandom_range(0, 10)], 26'($urandom)};
    endfunction

    logic [31:0] dir_ins [5];
    logic [31:0] dir_imm [5];

    initial begin
        dir_ins = '{32'h2008FFFF, 32'h3408FFFF, 32'h3C081234, 32'h3C08FFFF, 32'h08000010};
        dir_imm = '{32'hFFFFFFFF, 32'h0000FFFF, 32'h12340000, 32'hFFFF0000, 32'h00000010};
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
        #1 check_all();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_all();

        // add $3,$1,$2 into an empty buffer
        instr = 32'h00221820; in_valid = 1'b1; out_ready = 1'b1;
        step();
        check("add_rs", 64'(bus32.rs_out), 64'd1);
        check("add_rt", 64'(bus32.rt_out), 64'd2);
        check("add_rd", 64'(bus32.rd_out), 64'd3);
        check("add_func", 64'(bus32.func_out), 64'h20);
        check("add_count", 64'(bus32.count_out), 64'd1);

        // immediates and jump, streamed with the consumer always ready
        for (int i = 0; i < 5; i++) begin
            instr = dir_ins[i];
            step();
            check("dir_imm32", 64'(bus32.imm_ext_out), 64'(dir_imm[i]));
        end
        check("j_target", 64'(bus32.target_out), 64'h10);
        check("j_class", 64'(bus32.class_out), 64'd2);
        in_valid = 1'b0;
        step();

        // 64-bit lui extension
        instr = 32'h3C08FFFF; in_valid = 1'b1;
        step();
        check("lui64", bus64.imm_ext_out, 64'hFFFFFFFFFFFF0000);
        in_valid = 1'b0;
        step();

        // fill with consumer stalled; extra pushes must be dropped
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            instr = 32'h20000000 + 32'(i);
            step();
        end
        check("full_count", 64'(bus32.count_out), 64'(DEPTH));
        check("full_in_ready", {63'h0, bus32.in_ready}, 64'h0);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("drain_in_ready", {63'h0, bus32.in_ready}, 64'h1);
        repeat (DEPTH) step();

        // steady streaming at count==1
        instr = 32'h8C410004; in_valid = 1'b1; out_ready = 1'b0;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            instr = rand_instr();
            step();
            check("stream_count", 64'(bus32.count_out), 64'd1);
        end

        // flush with a simultaneous push
        out_ready = 1'b0; instr = 32'h24420001;
        step();
        check("pre_flush_count", 64'(bus32.count_out), 64'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid", {63'h0, bus32.out_valid}, 64'h0);
        check("flush_op", 64'(bus32.op_out), 64'h0);

        // asynchronous reset mid-stream clears outputs before any edge
        instr = 32'h3C08ABCD;
        step();
        #2 reset = 1'b1;
        #1;
        model_q.delete();
        check("areset_valid", {63'h0, bus32.out_valid}, 64'h0);
        check("areset_imm", bus64.imm_ext_out, 64'h0);
        check("areset_rt", 64'(bus32.rt_out), 64'h0);
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        check_all();

        // random traffic; the producer holds its word until it is taken
        last_push = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || last_push) instr = rand_instr();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
